// File: rtl/calc_pkg.sv
// Shared definitions for the 4-function calculator front end:
// op codes, sequencer states and default widths.
package calc_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int RES_W_DEF  = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_GET_A,
    S_GET_OP,
    S_GET_B,
    S_EXEC,
    S_WAIT,
    S_SHOW,
    S_ERR
  } state_t;

  // A divide whose divisor is zero never reaches the datapath.
  function automatic logic div_fault(input logic [1:0] op, input logic b_is_zero);
    return (op == OP_DIV) && b_is_zero;
  endfunction

endpackage

// File: rtl/calc_op_sequencer.sv
// Operand/op capture and execution handshake for the calculator datapath;
// holds the memory register that RECALL feeds back as the next operand.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [1:0]        sw_op,
  input  logic              key_enter,
  input  logic              key_recall,
  input  logic              key_clear,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [1:0]        op_select,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic [RES_W-1:0]  result_in,
  output logic [RES_W-1:0]  mem_value,
  output logic              result_valid,
  output logic              err,
  output logic              busy
);

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  state_t            state;
  logic [7:0]        tmo_cnt;
  logic [DATA_W-1:0] mem_low;
  logic [DATA_W-1:0] b_next;

  assign mem_low = mem_value[DATA_W-1:0];

  // Recall outranks enter, so it selects the B source whenever both are pressed.
  always_comb begin
    b_next = sw_data;
    if (key_recall) b_next = mem_low;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_GET_A;
      operand_a <= '0;
      operand_b <= '0;
      op_select <= '0;
      mem_value <= '0;
      tmo_cnt   <= '0;
    end else if (key_clear) begin
      state     <= S_GET_A;
      operand_a <= '0;
      operand_b <= '0;
      op_select <= '0;
    end else begin
      case (state)
        S_GET_A: begin
          if (key_recall) begin
            operand_a <= mem_low;
            state     <= S_GET_OP;
          end else if (key_enter) begin
            operand_a <= sw_data;
            state     <= S_GET_OP;
          end
        end
        S_GET_OP: begin
          // A recall here is swallowed and also masks a simultaneous enter.
          if (!key_recall && key_enter) begin
            op_select <= sw_op;
            state     <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (key_recall || key_enter) begin
            operand_b <= b_next;
            state     <= div_fault(op_select, b_next == '0) ? S_ERR : S_EXEC;
          end
        end
        S_EXEC: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (exec_done) begin
            mem_value <= result_in;
            state     <= S_SHOW;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_SHOW: begin
          if (key_recall) begin
            operand_a <= mem_low;
            state     <= S_GET_OP;
          end else if (key_enter) begin
            state <= S_GET_A;
          end
        end
        S_ERR: begin
          if (key_enter) state <= S_GET_A;
        end
        default: state <= S_GET_A;
      endcase
    end
  end

  assign exec_start   = (state == S_EXEC);
  assign busy         = (state == S_EXEC) || (state == S_WAIT);
  assign result_valid = (state == S_SHOW);
  assign err          = (state == S_ERR);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: plays the datapath side by hand and
// checks operand capture, chaining, error paths, timeout, clear and reset.
module tb_calc_op_sequencer;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_data = '0;
  logic [1:0] sw_op = '0;
  logic       key_enter = 1'b0, key_recall = 1'b0, key_clear = 1'b0;
  logic [3:0] operand_a, operand_b;
  logic [1:0] op_select;
  logic       exec_start, exec_done = 1'b0;
  logic [7:0] result_in = '0;
  logic [7:0] mem_value;
  logic       result_valid, err, busy;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int s0;

  calc_op_sequencer #(.DATA_W(4), .RES_W(8), .TMO_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .sw_op(sw_op),
    .key_enter(key_enter), .key_recall(key_recall), .key_clear(key_clear),
    .operand_a(operand_a), .operand_b(operand_b), .op_select(op_select),
    .exec_start(exec_start), .exec_done(exec_done), .result_in(result_in),
    .mem_value(mem_value), .result_valid(result_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (exec_start) starts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_enter();
    key_enter = 1'b1; tick(); key_enter = 1'b0;
  endtask

  task automatic press_recall();
    key_recall = 1'b1; tick(); key_recall = 1'b0;
  endtask

  task automatic press_clear();
    key_clear = 1'b1; tick(); key_clear = 1'b0;
  endtask

  task automatic pulse_done(input logic [7:0] r);
    exec_done = 1'b1; result_in = r; tick(); exec_done = 1'b0;
  endtask

  task automatic enter_calc(input logic [3:0] a, input logic [1:0] op, input logic [3:0] b);
    sw_data = a;  press_enter();
    sw_op   = op; press_enter();
    sw_data = b;  press_enter();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (dut.state !== S_GET_A) begin errors++; $display("FAIL rst_state: got %0d want %0d", dut.state, S_GET_A); end
    checks++; if ({operand_a, operand_b, op_select, mem_value} !== 18'h0) begin errors++; $display("FAIL rst_regs: got %0h want 0", {operand_a, operand_b, op_select, mem_value}); end
    checks++; if ({exec_start, result_valid, err, busy} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {exec_start, result_valid, err, busy}); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    s0 = starts;
    enter_calc(4'd3, OP_ADD, 4'd5);
    checks++; if (exec_start !== 1'b1) begin errors++; $display("FAIL add_start: got %b want 1", exec_start); end
    checks++; if ({operand_a, operand_b, op_select} !== {4'd3, 4'd5, 2'b00}) begin errors++; $display("FAIL add_ops: got %h want %h", {operand_a, operand_b, op_select}, {4'd3, 4'd5, 2'b00}); end
    tick();
    checks++; if ({exec_start, busy} !== 2'b01) begin errors++; $display("FAIL add_wait: got %b want 01", {exec_start, busy}); end
    tick();
    pulse_done(8'h08);
    checks++; if (mem_value !== 8'h08) begin errors++; $display("FAIL add_mem: got %0h want 08", mem_value); end
    checks++; if ({result_valid, busy, err} !== 3'b100) begin errors++; $display("FAIL add_show: got %b want 100", {result_valid, busy, err}); end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL add_pulses: got %0d want 1", starts - s0); end
    press_enter();
    checks++; if (dut.state !== S_GET_A || result_valid !== 1'b0) begin errors++; $display("FAIL add_newcalc: got state %0d rv %b want %0d 0", dut.state, result_valid, S_GET_A); end
  endtask

  task automatic test_mul_recall();
    enter_calc(4'd15, OP_MUL, 4'd15);
    tick();
    pulse_done(8'hE1);
    checks++; if (mem_value !== 8'hE1) begin errors++; $display("FAIL mul_mem: got %0h want e1", mem_value); end
    press_recall();
    checks++; if (operand_a !== 4'h1) begin errors++; $display("FAIL mul_chain_a: got %0h want 1", operand_a); end
    checks++; if (dut.state !== S_GET_OP) begin errors++; $display("FAIL mul_chain_state: got %0d want %0d", dut.state, S_GET_OP); end
    press_recall();
    checks++; if (dut.state !== S_GET_OP) begin errors++; $display("FAIL op_recall_ignored: got %0d want %0d", dut.state, S_GET_OP); end
    press_clear();
    checks++; if ({operand_a, operand_b, op_select} !== 10'h0) begin errors++; $display("FAIL clear_zero: got %h want 0", {operand_a, operand_b, op_select}); end
  endtask

  task automatic test_div_zero();
    s0 = starts;
    enter_calc(4'd7, OP_DIV, 4'd0);
    checks++; if (err !== 1'b1 || exec_start !== 1'b0) begin errors++; $display("FAIL div0_err: got err %b start %b want 1 0", err, exec_start); end
    tick();
    checks++; if (starts - s0 !== 0) begin errors++; $display("FAIL div0_pulses: got %0d want 0", starts - s0); end
    checks++; if (mem_value !== 8'hE1) begin errors++; $display("FAIL div0_mem: got %0h want e1", mem_value); end
    press_enter();
    checks++; if (err !== 1'b0 || dut.state !== S_GET_A) begin errors++; $display("FAIL div0_exit: got err %b state %0d want 0 %0d", err, dut.state, S_GET_A); end
  endtask

  task automatic test_timeout();
    enter_calc(4'd9, OP_DIV, 4'd3);
    checks++; if (exec_start !== 1'b1) begin errors++; $display("FAIL tmo_start: got %b want 1", exec_start); end
    tick();
    for (int unsigned i = 0; i < 254; i++) tick();
    checks++; if ({busy, err} !== 2'b10) begin errors++; $display("FAIL tmo_254: got %b want 10", {busy, err}); end
    tick();
    checks++; if ({busy, err} !== 2'b01) begin errors++; $display("FAIL tmo_255: got %b want 01", {busy, err}); end
    pulse_done(8'h55);
    checks++; if (mem_value !== 8'hE1 || err !== 1'b1) begin errors++; $display("FAIL tmo_late_done: got mem %0h err %b want e1 1", mem_value, err); end
    press_enter();
  endtask

  task automatic test_clear_in_wait();
    enter_calc(4'd2, OP_ADD, 4'd1);
    tick();
    press_clear();
    pulse_done(8'h03);
    checks++; if (dut.state !== S_GET_A) begin errors++; $display("FAIL clrwait_state: got %0d want %0d", dut.state, S_GET_A); end
    checks++; if (mem_value !== 8'hE1) begin errors++; $display("FAIL clrwait_mem: got %0h want e1", mem_value); end
    checks++; if ({operand_a, operand_b, op_select, result_valid} !== 11'h0) begin errors++; $display("FAIL clrwait_ops: got %h want 0", {operand_a, operand_b, op_select, result_valid}); end
  endtask

  task automatic test_priority_and_reset();
    sw_data = 4'd4; press_enter();
    sw_op = OP_SUB; press_enter();
    sw_data = 4'd6;
    key_clear = 1'b1; key_recall = 1'b1; key_enter = 1'b1;
    tick();
    key_clear = 1'b0; key_recall = 1'b0; key_enter = 1'b0;
    checks++; if (dut.state !== S_GET_A || operand_b !== 4'd0 || operand_a !== 4'd0) begin errors++; $display("FAIL prio_clear: got state %0d a %0h b %0h want %0d 0 0", dut.state, operand_a, operand_b, S_GET_A); end
    checks++; if (exec_start !== 1'b0) begin errors++; $display("FAIL prio_nostart: got %b want 0", exec_start); end
    enter_calc(4'd6, OP_SUB, 4'd2);
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({operand_a, operand_b, op_select, mem_value} !== 18'h0) begin errors++; $display("FAIL rstwait_regs: got %h want 0", {operand_a, operand_b, op_select, mem_value}); end
    checks++; if ({exec_start, result_valid, err, busy} !== 4'b0 || dut.state !== S_GET_A) begin errors++; $display("FAIL rstwait_flags: got %b state %0d want 0000 %0d", {exec_start, result_valid, err, busy}, dut.state, S_GET_A); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_recall();
    test_div_zero();
    test_timeout();
    test_clear_in_wait();
    test_priority_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
